// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sequencer and its settle timer.
package mux_scan_pkg;

    // Scan controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of the settle counter; holds SETTLE values 0..15.
    localparam int SETTLE_W = 4;

    // Highest select value reached during a scan of n_inputs inputs.
    function automatic int last_sel(input int n_inputs);
        return n_inputs - 1;
    endfunction

    // Last select value for the default four-input mux.
    localparam int LAST_SEL_DEFAULT = last_sel(4);

endpackage

// File: rtl/scan_settle_timer.sv
// Loadable down-counter that measures the settle wait at each select value.
module scan_settle_timer
    import mux_scan_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    input  logic                enable,
    output logic                zero
);

    logic [SETTLE_W-1:0] cnt_q;

    // Count register: load has priority; otherwise step down toward zero and stop there.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of block ordering.
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (enable && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps a mux select through every input, waits SETTLE cycles at each value,
// captures the mux output bit by bit and presents the word over valid/ready.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int N_INPUTS = 4,
    parameter int SEL_W    = 2,
    parameter int SETTLE   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [SEL_W-1:0]    sel,
    input  logic                mux_y,
    output logic [N_INPUTS-1:0] word,
    output logic                word_valid,
    input  logic                word_ready,
    output logic                busy
);

    localparam logic [SEL_W-1:0]    LAST_SEL   = SEL_W'(last_sel(N_INPUTS));
    localparam logic [SETTLE_W-1:0] SETTLE_VAL = SETTLE_W'(SETTLE);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [N_INPUTS-1:0] word_q, word_d;
    logic                valid_q, valid_d;

    logic timer_load;
    logic timer_enable;
    logic timer_zero;

    scan_settle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (SETTLE_VAL),
        .enable   (timer_enable),
        .zero     (timer_zero)
    );

    // State and datapath registers; reset aborts any scan and clears the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic: start in IDLE, settle-then-sample in SCAN, hold in DONE.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave a signal unassigned and infer a latch.
        state_d      = state_q;
        sel_d        = sel_q;
        word_d       = word_q;
        valid_d      = valid_q;
        timer_load   = 1'b0;
        timer_enable = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SCAN;
                    sel_d      = '0;
                    timer_load = 1'b1;
                end
            end
            SCAN: begin
                if (!timer_zero) begin
                    timer_enable = 1'b1;
                end else begin
                    // The mux output is sampled only once the settle wait has expired.
                    word_d[sel_q] = mux_y;
                    if (sel_q == LAST_SEL) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                    end else begin
                        sel_d      = sel_q + 1'b1;
                        timer_load = 1'b1;
                    end
                end
            end
            DONE: begin
                // A start on the handshake edge is deliberately not honoured.
                if (word_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign sel        = sel_q;
    assign word       = word_q;
    assign word_valid = valid_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboard bench for mux_scan_sequencer driving a behavioural 4:1 mux.
module tb_mux_scan_sequencer;

    localparam int N      = 4;
    localparam int SEL_W  = 2;
    localparam int SETTLE = 1;
    localparam int L      = N * (SETTLE + 1);   // edges from accept to word_valid

    typedef struct {
        logic [N-1:0] word;
        int           accept_cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [SEL_W-1:0] sel;
    logic             mux_y;
    logic [N-1:0]     word;
    logic             word_valid;
    logic             word_ready = 1'b0;
    logic             busy;

    logic [N-1:0]     d_q = '0;     // data inputs of the modelled mux
    exp_t             sb_q[$];
    exp_t             held;
    int               cyc = 0;
    int               n_vec = 0;
    int               n_err = 0;
    bit               vprev = 1'b0;

    mux_scan_sequencer #(.N_INPUTS(N), .SEL_W(SEL_W), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .sel        (sel),
        .mux_y      (mux_y),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy)
    );

    // Combinational 4:1 mux model.
    assign mux_y = d_q[sel];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: on the rising edge of word_valid pop and compare; while held, check stability.
    always @(negedge clk) begin
        if (rst_n && word_valid && !vprev) begin
            if (sb_q.size() == 0) begin
                check("unexpected_word_valid", 32'(word_valid), 32'd0);
            end else begin
                held = sb_q.pop_front();
                check("word", 32'(word), 32'(held.word));
                check("valid_latency", 32'(cyc - held.accept_cyc), 32'(L));
            end
        end else if (rst_n && word_valid && vprev) begin
            check("hold_word", 32'(word), 32'(held.word));
            check("hold_sel", 32'(sel), 32'(N - 1));
        end
        vprev = rst_n && word_valid;
    end

    // Bit i is sampled at edge (i+1)*(SETTLE+1) after accept; d changes right after edge k.
    function automatic logic [N-1:0] model_word(input logic [N-1:0] d0, input logic [N-1:0] d1,
                                                input int k);
        logic [N-1:0] w;
        for (int i = 0; i < N; i++)
            w[i] = (((i + 1) * (SETTLE + 1)) > k) ? d1[i] : d0[i];
        return w;
    endfunction

    // One complete scan with an optional mid-scan data change, backpressure and start pokes.
    task automatic run_scan(input logic [N-1:0] d0, input logic [N-1:0] d1, input int k,
                            input int ready_delay, input bit poke_start);
        exp_t e;
        int   exp_sel;
        @(negedge clk);
        d_q        = d0;
        start      = 1'b1;
        word_ready = (ready_delay == 0);
        @(negedge clk);                       // just after the accept edge
        e.word       = model_word(d0, d1, k);
        e.accept_cyc = cyc;
        sb_q.push_back(e);
        for (int j = 0; j <= L; j++) begin
            exp_sel = j / (SETTLE + 1);
            if (exp_sel > N - 1) exp_sel = N - 1;
            check("scan_sel", 32'(sel), 32'(exp_sel));
            check("scan_busy", 32'(busy), 32'd1);
            if (j == k) d_q = d1;
            start = poke_start && (j == 2 || j == 5);
            if (j < L) @(negedge clk);
        end
        start = 1'b0;
        if (ready_delay > 0) repeat (ready_delay) @(negedge clk);
        word_ready = 1'b1;
        start      = poke_start;              // must be ignored on the handshake edge
        @(negedge clk);
        check("release_valid", 32'(word_valid), 32'd0);
        check("release_busy", 32'(busy), 32'd0);
        word_ready = 1'b0;
        start      = 1'b0;
        @(negedge clk);
        check("stays_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #2;
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_word", 32'(word), 32'd0);
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic scan, ready already high.
        run_scan(4'b1010, 4'b1010, L, 0, 1'b0);
        // Backpressure for five cycles.
        run_scan(4'b0110, 4'b0110, L, 5, 1'b0);
        // Starts during SCAN and on the DONE handshake are ignored.
        run_scan(4'b0011, 4'b0011, L, 2, 1'b1);

        // Asynchronous reset while sel == 2, between clock edges.
        @(negedge clk);
        d_q   = 4'b1111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2 * (SETTLE + 1)) @(negedge clk);
        check("pre_reset_sel", 32'(sel), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_sel", 32'(sel), 32'd0);
        check("mid_rst_word", 32'(word), 32'd0);
        check("mid_rst_valid", 32'(word_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_scan(4'b1001, 4'b1001, L, 1, 1'b0);

        // Data changes while sel == 2: only bits 2 and 3 see the new value.
        run_scan(4'b0000, 4'b1111, 2 * (SETTLE + 1), 0, 1'b0);

        // Randomized scans.
        for (int r = 0; r < 20; r++) begin
            run_scan(N'($urandom), N'($urandom), int'($urandom_range(0, L)),
                     int'($urandom_range(0, 3)), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
